decode_stage: RTL and testbench

- Registered, parametrised instruction decode stage between fetch and register-read.
- Splits each 32-bit instruction word into register, immediate and address fields. Unused fields are forced to zero rather than held.
- Generates per-instruction control enables and an illegal-opcode flag.
- Valid/ready handshake on both sides, with a 2-entry elastic buffer (output register + skid register): full throughput, 1-cycle latency.

---
 rtl/decode_stage.sv | 202 ++++++++++++++++++++
 tb/tb_decode_stage.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
//
// Registered instruction decode stage that sits between fetch and register
// read. Each 32-bit instruction word is split combinationally into register,
// immediate and data-memory address fields, along with per-instruction control
// enables and an illegal-opcode flag. The decoded bundle is then captured in a
// 2-entry elastic buffer made of an output register and a skid register. This
// gives full throughput with a 1-cycle latency.
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   flush        in   synchronous flush; empties both buffer entries
//   in_valid     in   instruction word valid
//   in_ready     out  stage can accept a word (skid register empty)
//   instruction  in   32-bit instruction word, opcode = [31:26]
//   out_valid    out  decoded bundle valid
//   out_ready    in   consumer accepts the bundle
//   opcode       out  opcode passed through
//   rdst1/rdst2/rsrc1/rsrc2  out  register fields (REG_AW bits)
//   imm_value/src_address/dst_address  out  immediate and address (DATA_W bits)
//   rd1_we, rd2_we, rs1_re, rs2_re, mem_rd, mem_wr, imm_sel  out  enables
//   illegal      out  opcode is not defined (0x10-0x3F)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. A producer must hold valid and its data stable until that edge.
// The ready signal of this stage depends only on registered state and never
// on in_valid. A word offered while flush is high is never accepted.
// -----------------------------------------------------------------------------
module decode_stage #(
    parameter int DATA_W = 8,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instruction,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [5:0]        opcode,
    output logic [REG_AW-1:0] rdst1,
    output logic [REG_AW-1:0] rdst2,
    output logic [REG_AW-1:0] rsrc1,
    output logic [REG_AW-1:0] rsrc2,
    output logic [DATA_W-1:0] imm_value,
    output logic [DATA_W-1:0] src_address,
    output logic [DATA_W-1:0] dst_address,
    output logic              rd1_we,
    output logic              rd2_we,
    output logic              rs1_re,
    output logic              rs2_re,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic              imm_sel,
    output logic              illegal
);

    typedef struct packed {
        logic [5:0]        opcode;
        logic [REG_AW-1:0] rdst1;
        logic [REG_AW-1:0] rdst2;
        logic [REG_AW-1:0] rsrc1;
        logic [REG_AW-1:0] rsrc2;
        logic [DATA_W-1:0] imm_value;
        logic [DATA_W-1:0] src_address;
        logic [DATA_W-1:0] dst_address;
        logic              rd1_we;
        logic              rd2_we;
        logic              rs1_re;
        logic              rs2_re;
        logic              mem_rd;
        logic              mem_wr;
        logic              imm_sel;
        logic              illegal;
    } bundle_t;

    bundle_t dec;
    bundle_t out_q;
    bundle_t skid_q;
    logic    out_valid_q;
    logic    skid_valid;
    logic    accept;
    logic    pop;

    // Some instruction bits are unused for a given DATA_W/REG_AW. Folding
    // them into this sink keeps the port fully referenced.
    logic unused_instr;
    assign unused_instr = ^instruction;

    // Combinational decode. Fields that a class does not use stay at zero
    // rather than carrying stale bits.
    always_comb begin
        dec        = '0;
        dec.opcode = instruction[31:26];
        case (instruction[31:26])
            6'h00: begin // LDI
                dec.rdst1     = instruction[21 +: REG_AW];
                dec.imm_value = instruction[0 +: DATA_W];
                dec.rd1_we    = 1'b1;
                dec.imm_sel   = 1'b1;
            end
            6'h01, 6'h06, 6'h0E: begin // 2-reg
                dec.rdst1  = instruction[21 +: REG_AW];
                dec.rsrc1  = instruction[0 +: REG_AW];
                dec.rd1_we = 1'b1;
                dec.rs1_re = 1'b1;
            end
            6'h02: begin // LOAD
                dec.rdst1       = instruction[21 +: REG_AW];
                dec.src_address = instruction[0 +: DATA_W];
                dec.rd1_we      = 1'b1;
                dec.mem_rd      = 1'b1;
            end
            6'h03: begin // STORE: address sits just below the opcode
                dec.dst_address = instruction[25 -: DATA_W];
                dec.rsrc1       = instruction[0 +: REG_AW];
                dec.rs1_re      = 1'b1;
                dec.mem_wr      = 1'b1;
            end
            6'h04, 6'h05, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0F: begin // 3-reg
                dec.rsrc1  = instruction[0 +: REG_AW];
                dec.rsrc2  = instruction[5 +: REG_AW];
                dec.rdst1  = instruction[16 +: REG_AW];
                dec.rs1_re = 1'b1;
                dec.rs2_re = 1'b1;
                dec.rd1_we = 1'b1;
            end
            6'h07, 6'h08: begin // 4-reg: 3-reg plus a second destination
                dec.rsrc1  = instruction[0 +: REG_AW];
                dec.rsrc2  = instruction[5 +: REG_AW];
                dec.rdst1  = instruction[16 +: REG_AW];
                dec.rdst2  = instruction[21 +: REG_AW];
                dec.rs1_re = 1'b1;
                dec.rs2_re = 1'b1;
                dec.rd1_we = 1'b1;
                dec.rd2_we = 1'b1;
            end
            default: begin
                dec.illegal = 1'b1;
            end
        endcase
    end

    assign in_ready = !skid_valid;
    assign accept   = in_valid && in_ready && !flush;
    assign pop      = out_valid_q && out_ready;

    // Elastic buffer. The skid register only fills while the output register
    // is stalled. On the next pop, it drains into the output register, so
    // words always leave in arrival order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            skid_valid  <= 1'b0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
            skid_valid  <= 1'b0;
        end else if (!out_valid_q || pop) begin
            if (skid_valid) begin
                out_q       <= skid_q;
                out_valid_q <= 1'b1;
                if (accept) begin
                    skid_q <= dec;
                end else begin
                    skid_valid <= 1'b0;
                end
            end else if (accept) begin
                out_q       <= dec;
                out_valid_q <= 1'b1;
            end else begin
                out_valid_q <= 1'b0;
            end
        end else if (accept) begin
            skid_q     <= dec;
            skid_valid <= 1'b1;
        end
    end

    assign out_valid   = out_valid_q;
    assign opcode      = out_q.opcode;
    assign rdst1       = out_q.rdst1;
    assign rdst2       = out_q.rdst2;
    assign rsrc1       = out_q.rsrc1;
    assign rsrc2       = out_q.rsrc2;
    assign imm_value   = out_q.imm_value;
    assign src_address = out_q.src_address;
    assign dst_address = out_q.dst_address;
    assign rd1_we      = out_q.rd1_we;
    assign rd2_we      = out_q.rd2_we;
    assign rs1_re      = out_q.rs1_re;
    assign rs2_re      = out_q.rs2_re;
    assign mem_rd      = out_q.mem_rd;
    assign mem_wr      = out_q.mem_wr;
    assign imm_sel     = out_q.imm_sel;
    assign illegal     = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_decode_stage
//
// Self-checking bench for decode_stage. It runs the directed scenarios first
// and then a randomized run. Expected bundles come from a word-level decode
// model. Buffer behaviour comes from a queue of accepted words (exp_q).
// -----------------------------------------------------------------------------
module tb_decode_stage;

    localparam int DATA_W = 8;
    localparam int REG_AW = 5;
    localparam int BW     = 6 + 4 * REG_AW + 3 * DATA_W + 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       instruction;
    logic              out_valid;
    logic              out_ready;
    logic [5:0]        opcode;
    logic [REG_AW-1:0] rdst1, rdst2, rsrc1, rsrc2;
    logic [DATA_W-1:0] imm_value, src_address, dst_address;
    logic              rd1_we, rd2_we, rs1_re, rs2_re, mem_rd, mem_wr, imm_sel, illegal;

    decode_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .instruction(instruction),
        .out_valid(out_valid), .out_ready(out_ready),
        .opcode(opcode), .rdst1(rdst1), .rdst2(rdst2), .rsrc1(rsrc1), .rsrc2(rsrc2),
        .imm_value(imm_value), .src_address(src_address), .dst_address(dst_address),
        .rd1_we(rd1_we), .rd2_we(rd2_we), .rs1_re(rs1_re), .rs2_re(rs2_re),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .imm_sel(imm_sel), .illegal(illegal)
    );

    logic [BW-1:0] got;
    assign got = {opcode, rdst1, rdst2, rsrc1, rsrc2, imm_value, src_address, dst_address,
                  rd1_we, rd2_we, rs1_re, rs2_re, mem_rd, mem_wr, imm_sel, illegal};

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Reference decode written from the opcode table with plain arithmetic.
    function automatic logic [BW-1:0] model_decode(input logic [31:0] w);
        int unsigned op   = w >> 26;
        int unsigned s21  = (w >> 21) & 31;
        int unsigned s16  = (w >> 16) & 31;
        int unsigned s5   = (w >> 5) & 31;
        int unsigned s0   = w & 31;
        int unsigned dmsk = (1 << DATA_W) - 1;
        int unsigned rmsk = (1 << REG_AW) - 1;
        int unsigned lo   = w & dmsk;
        int unsigned hi   = (w >> (26 - DATA_W)) & dmsk;
        int unsigned d1 = 0, d2 = 0, r1 = 0, r2 = 0, imm = 0, src = 0, dst = 0;
        logic [7:0] fl = 8'h00; // rd1_we rd2_we rs1_re rs2_re mem_rd mem_wr imm_sel illegal
        if (op == 0) begin
            d1 = s21; imm = lo; fl = 8'b1000_0010;
        end else if (op == 1 || op == 6 || op == 14) begin
            d1 = s21; r1 = s0; fl = 8'b1010_0000;
        end else if (op == 2) begin
            d1 = s21; src = lo; fl = 8'b1000_1000;
        end else if (op == 3) begin
            dst = hi; r1 = s0; fl = 8'b0010_0100;
        end else if (op == 4 || op == 5 || (op >= 9 && op <= 13) || op == 15) begin
            r1 = s0; r2 = s5; d1 = s16; fl = 8'b1011_0000;
        end else if (op == 7 || op == 8) begin
            r1 = s0; r2 = s5; d1 = s16; d2 = s21; fl = 8'b1111_0000;
        end else begin
            fl = 8'b0000_0001;
        end
        d1 &= rmsk; d2 &= rmsk; r1 &= rmsk; r2 &= rmsk;
        return {op[5:0], d1[REG_AW-1:0], d2[REG_AW-1:0], r1[REG_AW-1:0], r2[REG_AW-1:0],
                imm[DATA_W-1:0], src[DATA_W-1:0], dst[DATA_W-1:0], fl};
    endfunction

    // ---------------- driver ----------------
    // Called at a falling edge. It drives one cycle of inputs, checks the
    // registered outputs against the model, advances the model at the rising
    // edge, and then returns at the next falling edge.
    task automatic step(input logic vld, input logic [31:0] w, input logic rdy, input logic fl);
        logic acc;
        logic pp;
        in_valid    = vld;
        instruction = w;
        out_ready   = rdy;
        flush       = fl;
        check("in_ready", {63'd0, in_ready}, {63'd0, exp_q.size() < 2});
        check("out_valid", {63'd0, out_valid}, {63'd0, exp_q.size() > 0});
        if (exp_q.size() > 0) check("bundle", got, model_decode(exp_q[0]));
        acc = vld && (exp_q.size() < 2) && !fl;
        pp  = (exp_q.size() > 0) && rdy;
        @(posedge clk);
        if (fl) begin
            exp_q.delete();
        end else begin
            if (pp) void'(exp_q.pop_front());
            if (acc) exp_q.push_back(w);
        end
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] r = $urandom;
        logic [5:0]  op;
        op = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(16, 63)) : 6'($urandom_range(0, 15));
        return {op, r[25:0]};
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        rst_n       = 1'b0;
        flush       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        instruction = '0;
        #3;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_bundle", got, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed decodes, one per cycle with the consumer always ready
        step(1'b1, 32'h002000A5, 1'b1, 1'b0);
        check("ldi", got, {6'h00, 5'd1, 5'd0, 5'd0, 5'd0, 8'hA5, 8'h00, 8'h00, 8'b1000_0010});
        step(1'b1, 32'h1C640041, 1'b1, 1'b0);
        check("reg4", got, {6'h07, 5'd4, 5'd3, 5'd1, 5'd2, 8'h00, 8'h00, 8'h00, 8'b1111_0000});
        step(1'b1, 32'h0D680007, 1'b1, 1'b0);
        check("store", got, {6'h03, 5'd0, 5'd0, 5'd7, 5'd0, 8'h00, 8'h00, 8'h5A, 8'b0010_0100});
        step(1'b1, 32'hFC000000, 1'b1, 1'b0);
        check("illegal", got, {6'h3F, 5'd0, 5'd0, 5'd0, 5'd0, 8'h00, 8'h00, 8'h00, 8'b0000_0001});
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // Back-to-back A, B, C into a stalled consumer, then drain
        step(1'b1, 32'h04000001, 1'b0, 1'b0);
        step(1'b1, 32'h08000002, 1'b0, 1'b0);
        check("full_in_ready", {63'd0, in_ready}, 64'd0);
        step(1'b1, 32'h2C000003, 1'b0, 1'b0);
        step(1'b1, 32'h2C000003, 1'b1, 1'b0);
        step(1'b1, 32'h2C000003, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // Flush with the stage full and C offered
        step(1'b1, 32'h04000011, 1'b0, 1'b0);
        step(1'b1, 32'h08000012, 1'b0, 1'b0);
        step(1'b1, 32'h2C000013, 1'b0, 1'b1);
        check("flush_out_valid", {63'd0, out_valid}, 64'd0);
        check("flush_in_ready", {63'd0, in_ready}, 64'd1);
        step(1'b1, 32'h3C000014, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // Asynchronous reset mid-stall with two words buffered
        step(1'b1, 32'h0400AB21, 1'b0, 1'b0);
        step(1'b1, 32'h0800CD22, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", {63'd0, out_valid}, 64'd0);
        check("arst_in_ready", {63'd0, in_ready}, 64'd1);
        check("arst_bundle", got, 64'd0);
        exp_q.delete();
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 32'h00E00033, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 9) < 7), rand_word(), ($urandom_range(0, 9) < 6),
                 ($urandom_range(0, 19) == 0));
        end
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
